// File: rtl/seg7_scan_buffer.sv
// seg7_scan_buffer: shift-register display buffer with a multiplexed 7-segment scanner.
// New patterns enter at digit 0 on each rising edge of seg_valid and push older
// digits toward NUM_DIGITS-1. A prescaler steps the scan index once per SCAN_DIV
// clocks. The active-low segment and digit drives are registered.
// Optional macro SEG7_SCAN_BLANK_EN darkens the display for the first
// BLANK_CYCLES clocks of every slot to suppress ghosting.
module seg7_scan_buffer #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [6:0]                      seg_in,
  input  logic                            seg_valid,
  input  logic                            clear,
  output logic [6:0]                      seg_out,
  output logic [NUM_DIGITS-1:0]           digit_en_n,
  output logic [$clog2(NUM_DIGITS+1)-1:0] fill_cnt
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = $clog2(NUM_DIGITS + 1);
  localparam logic [PW-1:0]         PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0]         FILL_MAX   = FW'(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0   = NUM_DIGITS'(1);
`ifdef SEG7_SCAN_BLANK_EN
  localparam logic [PW-1:0]         BLANK_END  = PW'(BLANK_CYCLES);
`endif

  logic [6:0]    digit [NUM_DIGITS];
  logic          valid_q;
  logic          load;
  logic [PW-1:0] presc;
  logic [IW-1:0] idx;

  // Only the first cycle of a high seg_valid counts as a load.
  assign load = seg_valid & ~valid_q;

  // Strobe edge detection, buffer shift on load, and clear (which wins and consumes the edge).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      fill_cnt <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= '0;
    end else begin
      valid_q <= seg_valid;
      if (clear) begin
        fill_cnt <= '0;
        for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= '0;
      end else if (load) begin
        digit[0] <= seg_in;
        for (int i = 1; i < NUM_DIGITS; i++) digit[i] <= digit[i-1];
        if (fill_cnt != FILL_MAX) fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end

  // Free-running prescaler and scan index, untouched by load and clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Registered active-low drive of the selected digit (dark in reset and in the blanking window).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg_out    <= 7'h7F;
      digit_en_n <= '1;
    end else begin
`ifdef SEG7_SCAN_BLANK_EN
      if (presc < BLANK_END) begin
        seg_out    <= 7'h7F;
        digit_en_n <= '1;
      end else begin
        seg_out    <= ~digit[idx];
        digit_en_n <= ~(ONE_HOT0 << idx);
      end
`else
      seg_out    <= ~digit[idx];
      digit_en_n <= ~(ONE_HOT0 << idx);
`endif
    end
  end

endmodule
